// File: rtl/div_pkg.sv
// Shared types and opcode helpers for the iterative divider.
package div_pkg;

    typedef enum logic [2:0] {
        DIV  = 3'b001,
        DIVU = 3'b010,
        REM  = 3'b011,
        REMU = 3'b100
    } divsel_e;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;

    function automatic logic is_valid(logic [2:0] sel);
        return sel inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic is_signed(divsel_e sel);
        return (sel == DIV) || (sel == REM);
    endfunction

    function automatic logic is_rem(divsel_e sel);
        return (sel == REM) || (sel == REMU);
    endfunction

endpackage

// File: rtl/div_iter_param_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_iter_param_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      divsel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] res;

    modport master (output start, divsel, a, b, kill, input busy, done, res);
    modport slave  (input start, divsel, a, b, kill, output busy, done, res);
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on magnitudes.
module div_step #(parameter int XLEN = 32) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            num_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem_in < divisor always holds, so the top bit of diff is a clean borrow flag.
    assign shifted = {rem_in, num_msb};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[XLEN];
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/div_iter_param.sv
// Iterative restoring divider, UNROLL quotient bits per cycle.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_iter_param
    import div_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input logic             clk,
    input logic             rst_n,
    div_iter_param_if.slave bus
);
    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS);

    div_state_e      state, state_next;
    logic [CW-1:0]   cnt;
    logic            neg_q, neg_r, op_rem;
    logic [XLEN-1:0] num, rem, divisor, res_pend;

    divsel_e         sel;
    logic            accept, sel_signed, a_neg, b_neg, b_zero, ovf, special, hit;
    logic [XLEN-1:0] a_mag, b_mag, q_fin, r_fin, rem_calc;
    logic [UNROLL-1:0] q_bits;

    assign sel        = divsel_e'(bus.divsel);
    assign accept     = ((state == IDLE) || (state == DONE)) && bus.start
                        && is_valid(bus.divsel) && !bus.kill;
    assign sel_signed = is_signed(sel);
    assign a_neg      = sel_signed & bus.a[XLEN-1];
    assign b_neg      = sel_signed & bus.b[XLEN-1];
    assign a_mag      = a_neg ? -bus.a : bus.a;
    assign b_mag      = b_neg ? -bus.b : bus.b;
    assign b_zero     = (bus.b == '0);
    assign ovf        = sel_signed && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b);
    assign special    = b_zero | ovf;
    assign bus.busy   = (state == CALC) || (state == FIX) || accept;

    assign q_fin = neg_q ? -num : num;
    assign r_fin = neg_r ? -rem : rem;

`ifdef DIV_RESULT_CACHE_EN
    logic            c_valid, c_signed, op_signed, op_special;
    logic [XLEN-1:0] c_a, c_b, c_q, c_r, op_a, op_b;
    assign hit = c_valid && (bus.a == c_a) && (bus.b == c_b) && (sel_signed == c_signed);
`else
    assign hit = 1'b0;
`endif

    // Step chain, MSB of the dividend consumed first.
    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        logic [XLEN-1:0] r_in, r_out;
        logic            q;
        if (i == 0) begin : g_first
            assign r_in = rem;
        end else begin : g_next
            assign r_in = g_step[i-1].r_out;
        end
        div_step #(.XLEN(XLEN)) u_step (
            .rem_in (r_in),
            .num_msb(num[XLEN-1-i]),
            .divisor(divisor),
            .rem_out(r_out),
            .q_bit  (q)
        );
        assign q_bits[UNROLL-1-i] = q;
    end
    assign rem_calc = g_step[UNROLL-1].r_out;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: default first so no path through this block leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) state_next = hit ? DONE : (special ? FIX : CALC);
                else        state_next = IDLE;
            end
            CALC:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (bus.kill) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            op_rem   <= 1'b0;
            num      <= '0;
            rem      <= '0;
            divisor  <= '0;
            res_pend <= '0;
            bus.done <= 1'b0;
            bus.res  <= '0;
`ifdef DIV_RESULT_CACHE_EN
            c_valid    <= 1'b0;
            c_signed   <= 1'b0;
            op_signed  <= 1'b0;
            op_special <= 1'b0;
            c_a <= '0; c_b <= '0; c_q <= '0; c_r <= '0;
            op_a <= '0; op_b <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            if ((state == DONE) && !bus.kill) begin
                bus.done <= 1'b1;
                bus.res  <= res_pend;
            end
            if (accept) begin
                // Special cases preload num/rem so FIX produces the architected result unchanged.
                neg_r   <= a_neg;
                neg_q   <= (a_neg ^ b_neg) & ~b_zero;
                op_rem  <= is_rem(sel);
                divisor <= b_mag;
                cnt     <= CW'(STEPS - 1);
                num     <= b_zero ? '1 : a_mag;
                rem     <= b_zero ? a_mag : '0;
`ifdef DIV_RESULT_CACHE_EN
                op_a       <= bus.a;
                op_b       <= bus.b;
                op_signed  <= sel_signed;
                op_special <= special;
                if (hit)          res_pend <= is_rem(sel) ? c_r : c_q;
                else if (special) c_valid  <= 1'b0;
`endif
            end else if (state == CALC) begin
                num <= {num[XLEN-UNROLL-1:0], q_bits};
                rem <= rem_calc;
                cnt <= cnt - 1'b1;
            end else if ((state == FIX) && !bus.kill) begin
                res_pend <= op_rem ? r_fin : q_fin;
`ifdef DIV_RESULT_CACHE_EN
                if (!op_special) begin
                    c_valid  <= 1'b1;
                    c_signed <= op_signed;
                    c_a      <= op_a;
                    c_b      <= op_b;
                    c_q      <= q_fin;
                    c_r      <= r_fin;
                end
`endif
            end
`ifdef DIV_RESULT_CACHE_EN
            if (bus.kill) c_valid <= 1'b0;
`endif
        end
    end
endmodule
